// File: rtl/arbitro_pkg.sv
// arbitro_pkg: default sizing, stall-mode encoding and one-hot decode shared by arbitro_wrr
package arbitro_pkg;
   localparam int NCH_DEF = 4;
   localparam int WEIGHT_W_DEF = 4;
   localparam logic [15:0] WEIGHTS_DEF = 16'h1234;
   localparam int NCH_MAX = 8;
   typedef enum logic {STALL_LAST = 1'b0, STALL_ALL = 1'b1} stall_mode_e;
   function automatic logic [NCH_MAX-1:0] onehot(input logic [2:0] idx);
      return NCH_MAX'(1) << idx;
   endfunction
endpackage

// File: rtl/arbitro_wrr_rr_search.sv
// rr_search: first set bit of mask_i at or after start_i, wrapping modulo N
module rr_search #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] mask_i,
   input  logic [W-1:0] start_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      // descending offsets so the nearest hit is the one left standing
      for (int k = N-1; k >= 0; k--) begin
         if (mask_i[(int'(start_i) + k) % N]) begin
            found_o = 1'b1;
            idx_o   = W'((int'(start_i) + k) % N);
         end
      end
   end
endmodule

// File: rtl/arbitro_wrr.sv
// arbitro_wrr: weighted round-robin pop arbiter with one-cycle-delayed push routing.
// Optional ARBITRO_WRR_STATS_EN adds per-channel saturating grant counters on grant_cnt.
module arbitro_wrr import arbitro_pkg::*; #(
   parameter int NCH = NCH_DEF,
   parameter int DEST_W = 2,
   parameter int WEIGHT_W = WEIGHT_W_DEF,
   parameter logic [NCH*WEIGHT_W-1:0] WEIGHTS = WEIGHTS_DEF,
   parameter int STALL_ANY = 1
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [NCH-1:0]    FIFO_empty,
   input  logic [NCH-1:0]    Almost_full,
   input  logic [DEST_W-1:0] dest,
   output logic [NCH-1:0]    Pops,
   output logic [NCH-1:0]    Push,
`ifdef ARBITRO_WRR_STATS_EN
   output logic [NCH*16-1:0] grant_cnt,
`endif
   output logic [DEST_W-1:0] grant_idx
);
   localparam stall_mode_e MODE = (STALL_ANY != 0) ? STALL_ALL : STALL_LAST;
   logic [NCH-1:0]      pops_q, pops_d, push_q, push_d, elig;
   logic [DEST_W-1:0]   gidx_q, gidx_d, ptr_q, ptr_d, lp_q, start, found_idx, g;
   logic [WEIGHT_W-1:0] cred_q, cred_d, c, w_g;
   logic                lpv_q, stall, found;

   always_comb begin
      for (int i = 0; i < NCH; i++) elig[i] = !FIFO_empty[i] && WEIGHTS[i*WEIGHT_W +: WEIGHT_W] != '0;
   end

   assign start = (int'(ptr_q) == NCH-1) ? '0 : ptr_q + 1'b1;
   assign stall = (MODE == STALL_ALL) ? |Almost_full : lpv_q && Almost_full[lp_q];

   // the search wraps through every channel, so found doubles as "anything eligible"
   rr_search #(.N(NCH), .W(DEST_W)) u_search (
      .mask_i  (elig),
      .start_i (start),
      .found_o (found),
      .idx_o   (found_idx)
   );

   always_comb begin
      g      = elig[ptr_q] ? ptr_q : found_idx;
      c      = elig[ptr_q] ? cred_q + 1'b1 : WEIGHT_W'(1);
      w_g    = WEIGHTS[int'(g)*WEIGHT_W +: WEIGHT_W];
      pops_d = '0;
      gidx_d = gidx_q;
      ptr_d  = ptr_q;
      cred_d = cred_q;
      if (!stall && found) begin
         pops_d = NCH'(onehot(3'(g)));
         gidx_d = g;
         ptr_d  = (c == w_g) ? ((int'(g) == NCH-1) ? '0 : g + 1'b1) : g;
         cred_d = (c == w_g) ? '0 : c;
      end
      push_d = (pops_q != '0 && int'(dest) < NCH) ? NCH'(onehot(3'(dest))) : '0;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         pops_q <= '0;
         push_q <= '0;
         gidx_q <= '0;
         ptr_q  <= '0;
         cred_q <= '0;
         lp_q   <= '0;
         lpv_q  <= 1'b0;
      end else begin
         pops_q <= pops_d;
         push_q <= push_d;
         gidx_q <= gidx_d;
         ptr_q  <= ptr_d;
         cred_q <= cred_d;
         if (push_d != '0) begin
            lp_q  <= dest;
            lpv_q <= 1'b1;
         end
      end
   end

   assign Pops      = pops_q;
   assign Push      = push_q;
   assign grant_idx = gidx_q;

`ifdef ARBITRO_WRR_STATS_EN
   logic [NCH*16-1:0] cnt_q;
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) cnt_q <= '0;
      else for (int i = 0; i < NCH; i++)
         if (pops_d[i] && cnt_q[i*16 +: 16] != 16'hFFFF) cnt_q[i*16 +: 16] <= cnt_q[i*16 +: 16] + 16'd1;
   end
   assign grant_cnt = cnt_q;
`endif
endmodule

// File: doc/arbitro_wrr.md
ARBITRO_WRR -- requirements
Module: arbitro_wrr

Interface
REQ-001 Parameter NCH, default 4: number of FIFO channels, 2..8.
REQ-002 Parameter DEST_W, default 2: destination index width, equals clog2(NCH).
REQ-003 Parameter WEIGHT_W, default 4: width of each per-channel weight.
REQ-004 Parameter WEIGHTS, default 16'h1234: packed weights, channel i in bits [i*WEIGHT_W +: WEIGHT_W]; default gives P0=4, P1=3, P2=2, P3=1.
REQ-005 Parameter STALL_ANY, default 1: 1 = any Almost_full bit stalls; 0 = only the Almost_full bit of the last Push target stalls.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset_L  input  1  asynchronous, active-low reset.
REQ-008 FIFO_empty  input  NCH  per-channel source FIFO empty flag.
REQ-009 Almost_full  input  NCH  per-channel destination FIFO almost-full flag.
REQ-010 dest  input  DEST_W  destination of the word currently read out of the popped FIFO.
REQ-011 Pops  output  NCH  registered one-hot (or zero) pop strobe to source FIFOs.
REQ-012 Push  output  NCH  registered one-hot (or zero) push strobe to destination FIFOs.
REQ-013 grant_idx  output  DEST_W  registered index of the channel popped in the current cycle; holds when Pops=0.

Function
REQ-014 Eligible[i] = !FIFO_empty[i] && weight[i]!=0; weight-0 channels are never popped.
REQ-015 Stall = |Almost_full when STALL_ANY=1, else Almost_full[last push index] once any push has occurred since reset.
REQ-016 Internal state: pointer ptr (DEST_W bits) and credit cred (WEIGHT_W bits).
REQ-017 At each edge with Stall or no eligible channel: Pops<=0, ptr and cred hold.
REQ-018 Else if Eligible[ptr]: grant ptr, cred<=cred+1.
REQ-019 Else: grant first eligible channel j searching ptr+1..ptr+NCH-1 modulo NCH, ptr<=j, cred<=1.
REQ-020 After any grant, if new cred equals weight of granted channel: ptr<=granted+1 modulo NCH, cred<=0.
REQ-021 Grant drives Pops<=onehot(granted) and grant_idx<=granted at the same edge; at most one Pops bit high per cycle.
REQ-022 Push latency: at each edge, Push<=onehot(dest) if Pops!=0, else Push<=0; Push is exactly one cycle after its Pops.
REQ-023 dest values >= NCH produce Push=0.
REQ-024 Stall never suppresses a Push already owed by a prior Pops.
REQ-025 Full fairness: with all channels eligible and no stall, every window of sum(WEIGHTS) consecutive grants contains exactly weight[i] grants of channel i, in order P0 x4, P1 x3, P2 x2, P3 x1 for defaults.

Reset
REQ-026 While reset_L=0: Pops=0, Push=0, grant_idx=0, ptr=0, cred=0, last push index cleared, stats counters 0.
REQ-027 Reset assertion mid-sequence takes effect immediately (asynchronous); release resumes arbitration at P0 with full credit on the first edge after release.

Configuration
REQ-028 Macro ARBITRO_WRR_STATS_EN defined: adds output grant_cnt (NCH*16 bits), one saturating 16-bit counter per channel incremented on each Pops grant of that channel.
REQ-029 Macro undefined: grant_cnt port and counters absent; all other behaviour identical.

Structure
REQ-030 Shared package arbitro_pkg holds the onehot-decode function, default NCH/WEIGHT_W/WEIGHTS constants and the stall-mode encoding.
REQ-031 The round-robin next-eligible search is one sub-module, rr_search (inputs eligible mask, start index; outputs found flag and index).

Verification
REQ-032 All FIFO_empty=0, Almost_full=0, defaults, 20 cycles -> Pops sequence 1,1,1,1,2,2,2,4,4,8 repeating twice.
REQ-033 FIFO_empty=4'b0001 (P0 empty), others full -> P1 x3, P2 x2, P3 x1 repeating; Pops never 4'b0001.
REQ-034 Almost_full=4'b0100 asserted for 3 cycles mid-P1 burst, STALL_ANY=1 -> Pops=0 for those 3 cycles, P1 burst resumes with remaining credit.
REQ-035 Pops=4'b0010 with dest=3 -> next cycle Push=4'b1000; dest=0 with Pops=0 -> Push=0.
REQ-036 reset_L pulled low between clock edges during P2 grant -> Pops/Push/grant_idx 0 immediately; after release first grant is P0.
REQ-037 ARBITRO_WRR_STATS_EN defined, 1000 full-load cycles -> grant_cnt values 400/300/200/100.
